// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Brief    : Receives a length-prefixed byte stream and writes it word by word
//            into the instruction memory from BASE_ADDR (little-endian).
//            Optional trailing XOR checksum: define LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
  parameter int                 A_WIDTH     = 32,
  parameter int                 D_WIDTH     = 8,
  parameter logic [A_WIDTH-1:0] BASE_ADDR   = 32'hBFC00000,
  parameter int                 DEPTH_BYTES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rx_valid,
  input  logic [D_WIDTH-1:0]     rx_data,
  output logic                   rx_ready,
  output logic                   mem_we,
  output logic [A_WIDTH-1:0]     mem_addr,
  output logic [4*D_WIDTH-1:0]   mem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            word_count
);

  localparam logic [16:0] MAX_WORDS = 17'(DEPTH_BYTES / 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t               state, state_nxt;
  logic [15:0]          len_q;
  logic [D_WIDTH-1:0]   len_lo;
  logic                 lo_seen;
  logic [1:0]           lane;
  logic [4*D_WIDTH-1:0] word_buf;
  logic [15:0]          wc_q;
  logic [15:0]          len_in;
`ifdef LOADER_CHECKSUM_EN
  logic [D_WIDTH-1:0]   csum;
`endif

  assign len_in     = 16'({rx_data, len_lo});
  assign mem_wdata  = word_buf;
  assign word_count = wc_q;
  // Address derived from the word counter so it is word-aligned by construction
  assign mem_addr   = BASE_ADDR + A_WIDTH'({wc_q, 2'b00});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        done = (state == S_DONE);
        err  = (state == S_ERR);
        if (start) state_nxt = S_LEN;
      end
      S_LEN: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid && lo_seen) begin
          if (len_in == 16'd0)                 state_nxt = S_DONE;
          else if ({1'b0, len_in} > MAX_WORDS) state_nxt = S_ERR;
          else                                 state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid && lane == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        if (wc_q + 16'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CHK;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      len_lo   <= '0;
      lo_seen  <= 1'b0;
      lane     <= 2'd0;
      word_buf <= '0;
      wc_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            wc_q    <= '0;
            lo_seen <= 1'b0;
            lane    <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            if (!lo_seen) begin
              len_lo  <= rx_data;
              lo_seen <= 1'b1;
            end else begin
              len_q   <= len_in;
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            word_buf[int'(lane)*D_WIDTH +: D_WIDTH] <= rx_data;
            lane <= lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
          end
        end
        S_WRITE: wc_q <= wc_q + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// Testbench for instr_mem_loader: random byte streams with gaps, compared
// against an image-level model of the expected memory writes and flags.
module tb_instr_mem_loader;

  logic        clk, rst, start, rx_valid, rx_ready, mem_we, busy, done, err;
  logic [7:0]  rx_data;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] word_count;

  int errors = 0;
  int checks = 0;

  logic [7:0]  img[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  instr_mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rand(input int n);
    img.delete();
    repeat (n) img.push_back(8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat ($urandom_range(gap, 0)) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      check("rdy_timeout", {63'd0, rx_ready}, 64'd1);
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Whole-load model: image -> expected write list, flags and word count.
  task automatic run_load(input int len_val, input int gap, input bit bad_chk,
                          input bit poke_start, input string tag);
    logic [15:0] lv;
    logic [7:0]  x;
    bit          len_ok, exp_done;
    int          exp_wc, nchk;
    lv = 16'(len_val);
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    pulse_start();
    send_byte(lv[7:0], gap);
    send_byte(lv[15:8], gap);
    len_ok = (len_val >= 1 && len_val <= 1024);
    if (len_ok && poke_start) pulse_start();
    x = 8'd0;
    if (len_ok) begin
      foreach (img[i]) begin
        send_byte(img[i], gap);
        x ^= img[i];
      end
    end
    exp_done = (len_val == 0) || len_ok;
`ifdef LOADER_CHECKSUM_EN
    if (len_ok) begin
      send_byte(x ^ {7'd0, bad_chk}, gap);
      if (bad_chk) exp_done = 1'b0;
    end
`endif
    wait_idle();
    @(negedge clk);
    exp_wc = len_ok ? len_val : 0;
    check($sformatf("%s.done", tag), {63'd0, done}, {63'd0, exp_done});
    check($sformatf("%s.err", tag), {63'd0, err}, {63'd0, !exp_done});
    check($sformatf("%s.busy", tag), {63'd0, busy}, 64'd0);
    check($sformatf("%s.wc", tag), {48'd0, word_count}, 64'(exp_wc));
    check($sformatf("%s.nwr", tag), 64'(wr_addr.size()), 64'(exp_wc));
    nchk = (wr_addr.size() < exp_wc) ? wr_addr.size() : exp_wc;
    for (int i = 0; i < nchk; i++) begin
      check($sformatf("%s.addr%0d", tag, i), {32'd0, wr_addr[i]}, {32'd0, 32'hBFC00000 + 32'(4 * i)});
      check($sformatf("%s.data%0d", tag, i), {32'd0, wr_data[i]},
            {32'd0, img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s.rdy", tag), {63'd0, rx_ready}, 64'd0);
    check($sformatf("%s.we", tag), {63'd0, mem_we}, 64'd0);
    check($sformatf("%s.busy", tag), {63'd0, busy}, 64'd0);
    check($sformatf("%s.done", tag), {63'd0, done}, 64'd0);
    check($sformatf("%s.err", tag), {63'd0, err}, 64'd0);
    check($sformatf("%s.wc", tag), {48'd0, word_count}, 64'd0);
    check($sformatf("%s.addr", tag), {32'd0, mem_addr}, 64'h0BFC00000);
    check($sformatf("%s.wdata", tag), {32'd0, mem_wdata}, 64'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    // Asynchronous reset between clock edges
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst0");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    img = '{8'h13, 8'h05, 8'h00, 8'h00};
    run_load(1, 0, 1'b0, 1'b0, "single");
    if (wr_data.size() == 1) check("single.word", {32'd0, wr_data[0]}, 64'h00000513);

    fill_rand(8);
    run_load(2, 3, 1'b0, 1'b1, "two_gaps");

    img.delete();
    run_load(1025, 1, 1'b0, 1'b0, "len_over");
    img.delete();
    run_load(0, 1, 1'b0, 1'b0, "len_zero");

    fill_rand(4096);
    run_load(1024, 0, 1'b0, 1'b0, "len_max");
    if (wr_addr.size() == 1024) check("len_max.last", {32'd0, wr_addr[1023]}, 64'h0BFC00FFC);

    // Reset in the middle of word 0
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid.nwr", 64'(wr_addr.size()), 64'd0);
    img = '{8'h13, 8'h05, 8'h00, 8'h00};
    run_load(1, 2, 1'b0, 1'b0, "reload");

    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(6, 1);
      fill_rand(4 * n);
      run_load(n, $urandom_range(3, 0), 1'b0, 1'($urandom_range(1, 0)), $sformatf("rnd%0d", k));
    end

`ifdef LOADER_CHECKSUM_EN
    img = '{8'h13, 8'h05, 8'h00, 8'h00};
    run_load(1, 1, 1'b0, 1'b0, "chk_good");
    run_load(1, 1, 1'b1, 1'b0, "chk_bad");
    fill_rand(12);
    run_load(3, 2, 1'b1, 1'b0, "chk_bad3");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
